// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared types and default constants for the pipeline stall/flush sequencer.
//   DRAIN_CYCLES : cycles from Halt leaving ID until Halt has spent one cycle in WB.
//   MEM_TIMEOUT  : consecutive data-memory wait cycles tolerated before error.
//   seq_state_e  : sequencer state (RUN, DRAIN, HALTED).
package pipeline_pkg;

   localparam int unsigned DRAIN_CYCLES = 3;
   localparam int unsigned MEM_TIMEOUT  = 15;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } seq_state_e;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// pipeline_sequencer_if
// Bundles the decoded ID/EX/MEM control bits going into the sequencer and the
// per-stage enable/flush controls coming out of it.
//   master : decoder/datapath side (drives hazard inputs, receives controls).
//   slave  : sequencer side (receives hazard inputs, drives controls).
interface pipeline_sequencer_if;

   // Decoded inputs to the sequencer
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic [4:0] ex_rd;
   logic       ex_mem_read;
   logic       ex_branch_taken;
   logic       id_halt;
   logic       mem_req;
   logic       dmem_ready;

   // Controls from the sequencer
   logic       pc_en;
   logic       if_id_en;
   logic       id_ex_en;
   logic       ex_mem_en;
   logic       if_id_flush;
   logic       id_ex_flush;
   logic       mem_wb_flush;
   logic       halted;
   logic       mem_err;

   modport master (
      output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken, id_halt, mem_req,
             dmem_ready,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush,
             halted, mem_err
   );

   modport slave (
      input  id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken, id_halt, mem_req,
             dmem_ready,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush,
             halted, mem_err
   );

endinterface

// File: rtl/hazard_detect.sv
// hazard_detect
// Combinational load-use comparator. Flags a hazard when the load in EX writes a
// non-zero register that the instruction in ID names as rs1 or rs2. Conservative:
// it does not check whether ID actually reads each rs field.
//   i_id_rs1, i_id_rs2 : source register fields in ID
//   i_ex_rd            : destination register in EX
//   i_ex_mem_read      : EX instruction is a load
//   o_load_use         : stall request
module hazard_detect (
   input  logic [4:0] i_id_rs1,
   input  logic [4:0] i_id_rs2,
   input  logic [4:0] i_ex_rd,
   input  logic       i_ex_mem_read,
   output logic       o_load_use
);

   logic w_rd_nonzero;
   logic w_rd_match;

   assign w_rd_nonzero = (i_ex_rd != 5'd0);
   assign w_rd_match   = (i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2);
   assign o_load_use   = i_ex_mem_read && w_rd_nonzero && w_rd_match;

endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
// Central stall/flush sequencer for the 5-stage pipeline. Combines memory waits,
// taken branches, Halt and load-use hazards into PC / pipeline register enables and
// bubble flushes, owns the halt-drain FSM and the data-memory timeout.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : slave side of pipeline_sequencer_if (hazard inputs in, controls out)
// Enables/flushes are combinational; halted and mem_err are registered.
module pipeline_sequencer #(
   parameter int unsigned DRAIN_CYCLES = pipeline_pkg::DRAIN_CYCLES,
   parameter int unsigned MEM_TIMEOUT  = pipeline_pkg::MEM_TIMEOUT
) (
   input logic                 clk,
   input logic                 reset,
   pipeline_sequencer_if.slave bus
);

   import pipeline_pkg::*;

   localparam int unsigned DRN_W  = $clog2(DRAIN_CYCLES + 1);
   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   seq_state_e         r_state;
   seq_state_e         w_state_nxt;
   logic [DRN_W-1:0]   r_drain_cnt;
   logic [DRN_W-1:0]   w_drain_cnt_nxt;
   logic [WAIT_W-1:0]  r_wait_cnt;
   logic [WAIT_W-1:0]  w_wait_cnt_nxt;
   logic               r_halted;
   logic               r_mem_err;
   logic               w_mem_err_nxt;

   logic w_mem_wait;
   logic w_timeout;
   logic w_load_use;

   logic w_pc_en;
   logic w_if_id_en;
   logic w_id_ex_en;
   logic w_ex_mem_en;
   logic w_if_id_flush;
   logic w_id_ex_flush;
   logic w_mem_wb_flush;

   hazard_detect u_hazard_detect (
      .i_id_rs1      (bus.id_rs1),
      .i_id_rs2      (bus.id_rs2),
      .i_ex_rd       (bus.ex_rd),
      .i_ex_mem_read (bus.ex_mem_read),
      .o_load_use    (w_load_use)
   );

   assign w_mem_wait = bus.mem_req && !bus.dmem_ready;
   // This wait cycle would be the MEM_TIMEOUT-th in a row.
   assign w_timeout  = w_mem_wait && (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= RUN;
         r_drain_cnt <= '0;
         r_wait_cnt  <= '0;
         r_mem_err   <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= w_drain_cnt_nxt;
         r_wait_cnt  <= w_wait_cnt_nxt;
         r_mem_err   <= w_mem_err_nxt;
         r_halted    <= (w_state_nxt == HALTED);
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_drain_cnt_nxt = r_drain_cnt;
      w_wait_cnt_nxt  = w_mem_wait ? (r_wait_cnt + 1'b1) : '0;
      w_mem_err_nxt   = r_mem_err;

      w_pc_en         = 1'b1;
      w_if_id_en      = 1'b1;
      w_id_ex_en      = 1'b1;
      w_ex_mem_en     = 1'b1;
      w_if_id_flush   = 1'b0;
      w_id_ex_flush   = 1'b0;
      w_mem_wb_flush  = 1'b0;

      unique case (r_state)
         RUN: begin
            if (w_mem_wait) begin
               // Freeze everything up to MEM; WB gets a bubble.
               w_pc_en        = 1'b0;
               w_if_id_en     = 1'b0;
               w_id_ex_en     = 1'b0;
               w_ex_mem_en    = 1'b0;
               w_mem_wb_flush = 1'b1;
               if (w_timeout) begin
                  w_state_nxt   = HALTED;
                  w_mem_err_nxt = 1'b1;
               end
            end else if (bus.ex_branch_taken) begin
               // Halt in ID is on the wrong path here and is squashed with it.
               w_if_id_flush = 1'b1;
               w_id_ex_flush = 1'b1;
            end else if (bus.id_halt) begin
               w_pc_en         = 1'b0;
               w_if_id_flush   = 1'b1;
               w_state_nxt     = DRAIN;
               w_drain_cnt_nxt = DRN_W'(DRAIN_CYCLES);
            end else if (w_load_use) begin
               w_pc_en       = 1'b0;
               w_if_id_en    = 1'b0;
               w_id_ex_flush = 1'b1;
            end
         end

         DRAIN: begin
            w_pc_en       = 1'b0;
            w_if_id_flush = 1'b1;
            if (w_mem_wait) begin
               // Frozen cycle: drain count holds so WB still sees Halt for a full cycle.
               w_if_id_en     = 1'b0;
               w_id_ex_en     = 1'b0;
               w_ex_mem_en    = 1'b0;
               w_mem_wb_flush = 1'b1;
               if (w_timeout) begin
                  w_state_nxt   = HALTED;
                  w_mem_err_nxt = 1'b1;
               end
            end else begin
               w_drain_cnt_nxt = r_drain_cnt - 1'b1;
               if (r_drain_cnt == DRN_W'(1)) begin
                  w_state_nxt = HALTED;
               end
            end
         end

         HALTED: begin
            w_pc_en        = 1'b0;
            w_if_id_en     = 1'b0;
            w_id_ex_en     = 1'b0;
            w_ex_mem_en    = 1'b0;
            w_wait_cnt_nxt = '0;
         end

         default: begin
            w_state_nxt = RUN;
         end
      endcase

      // Reset holds the pipeline with bubbles in every stage register.
      if (reset) begin
         w_pc_en        = 1'b0;
         w_if_id_en     = 1'b0;
         w_id_ex_en     = 1'b0;
         w_ex_mem_en    = 1'b0;
         w_if_id_flush  = 1'b1;
         w_id_ex_flush  = 1'b1;
         w_mem_wb_flush = 1'b1;
      end
   end

   assign bus.pc_en        = w_pc_en;
   assign bus.if_id_en     = w_if_id_en;
   assign bus.id_ex_en     = w_id_ex_en;
   assign bus.ex_mem_en    = w_ex_mem_en;
   assign bus.if_id_flush  = w_if_id_flush;
   assign bus.id_ex_flush  = w_id_ex_flush;
   assign bus.mem_wb_flush = w_mem_wb_flush;
   assign bus.halted       = r_halted;
   assign bus.mem_err      = r_mem_err;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer
// Scoreboard bench: each stimulus cycle pushes the reference model's expected outputs
// into a queue; a monitor on the falling edge pops and compares against the DUT.
module tb_pipeline_sequencer;

   localparam int unsigned DRAIN_CYCLES = 3;
   localparam int unsigned MEM_TIMEOUT  = 15;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       mr;
      logic       br;
      logic       halt;
      logic       mreq;
      logic       dready;
   } stim_t;

   // comb = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush}
   typedef struct {
      logic [6:0] comb;
      logic [1:0] regs;   // {halted, mem_err}
      bit         chk_reg;
      int         cyc;
   } exp_t;

   logic clk;
   logic reset;
   pipeline_sequencer_if bus ();

   pipeline_sequencer #(
      .DRAIN_CYCLES (DRAIN_CYCLES),
      .MEM_TIMEOUT  (MEM_TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   // Reference model: what the pipeline is doing, in plain terms.
   bit m_draining   = 0;
   int m_drain_left = 0;   // cycles of drain still owed to the Halt instruction
   int m_waits      = 0;   // consecutive memory wait cycles so far
   bit m_halted     = 0;
   bit m_err        = 0;

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.rs1 = 5'd1;
      s.rs2 = 5'd2;
      s.rd  = 5'd3;
      return s;
   endfunction

   function automatic stim_t rnd();
      stim_t s;
      s.rs1    = 5'($urandom_range(3));
      s.rs2    = 5'($urandom_range(3));
      s.rd     = 5'($urandom_range(3));
      s.mr     = ($urandom_range(99) < 40);
      s.br     = ($urandom_range(99) < 12);
      s.halt   = ($urandom_range(99) < 4);
      s.mreq   = ($urandom_range(99) < 35);
      s.dready = ($urandom_range(99) < 55);
      return s;
   endfunction

   // One clock cycle: drive, predict, wait for the edge, advance the model.
   task automatic step(input logic rst, input stim_t s);
      exp_t e;
      bit   pc, ifid, idex, exmem, fl_ifid, fl_idex, fl_memwb;
      bit   waiting, hazard;
      bit   n_draining, n_halted, n_err;
      int   n_drain_left, n_waits;

      reset               = rst;
      bus.id_rs1          = s.rs1;
      bus.id_rs2          = s.rs2;
      bus.ex_rd           = s.rd;
      bus.ex_mem_read     = s.mr;
      bus.ex_branch_taken = s.br;
      bus.id_halt         = s.halt;
      bus.mem_req         = s.mreq;
      bus.dmem_ready      = s.dready;

      waiting = s.mreq && !s.dready;
      hazard  = s.mr && (s.rd != 0) && (s.rd == s.rs1 || s.rd == s.rs2);

      {pc, ifid, idex, exmem} = 4'b1111;
      {fl_ifid, fl_idex, fl_memwb} = 3'b000;
      n_draining = m_draining;
      n_drain_left = m_drain_left;
      n_waits = 0;
      n_halted = m_halted;
      n_err = m_err;

      if (rst) begin
         {pc, ifid, idex, exmem} = 4'b0000;
         {fl_ifid, fl_idex, fl_memwb} = 3'b111;
         n_draining = 0;
         n_drain_left = 0;
         n_halted = 0;
         n_err = 0;
      end else if (m_halted) begin
         {pc, ifid, idex, exmem} = 4'b0000;
      end else begin
         if (m_draining) begin
            pc = 0;
            fl_ifid = 1;
         end
         if (waiting) begin
            {pc, ifid, idex, exmem} = 4'b0000;
            fl_memwb = 1;
            n_waits = m_waits + 1;
            if (n_waits == MEM_TIMEOUT) begin
               n_halted = 1;
               n_err = 1;
            end
         end else if (m_draining) begin
            n_drain_left = m_drain_left - 1;
            if (n_drain_left == 0) n_halted = 1;
         end else if (s.br) begin
            fl_ifid = 1;
            fl_idex = 1;
         end else if (s.halt) begin
            pc = 0;
            fl_ifid = 1;
            n_draining = 1;
            n_drain_left = DRAIN_CYCLES;
         end else if (hazard) begin
            pc = 0;
            ifid = 0;
            fl_idex = 1;
         end
      end

      e.comb    = {pc, ifid, idex, exmem, fl_ifid, fl_idex, fl_memwb};
      e.regs    = {m_halted, m_err};
      e.chk_reg = !rst;
      e.cyc     = cyc;
      exp_q.push_back(e);

      @(posedge clk);
      #1;
      m_draining   = n_halted ? 1'b0 : n_draining;
      m_drain_left = n_drain_left;
      m_waits      = n_waits;
      m_halted     = n_halted;
      m_err        = n_err;
      cyc++;
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(1'b0, idle());
   endtask

   // Monitor: compare whenever an expectation is outstanding for this cycle.
   exp_t       mon_e;
   logic [6:0] mon_comb;
   logic [1:0] mon_regs;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e    = exp_q.pop_front();
         mon_comb = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
                     bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush};
         mon_regs = {bus.halted, bus.mem_err};
         n_checks++;
         if (mon_comb === mon_e.comb) n_pass++;
         else $display("FAIL controls cyc=%0d {pc,ifid,idex,exmem,fl_ifid,fl_idex,fl_memwb} got %b want %b",
                       mon_e.cyc, mon_comb, mon_e.comb);
         if (mon_e.chk_reg) begin
            n_checks++;
            if (mon_regs === mon_e.regs) n_pass++;
            else $display("FAIL status cyc=%0d {halted,mem_err} got %b want %b",
                          mon_e.cyc, mon_regs, mon_e.regs);
         end
      end
   end

   initial begin
      stim_t s;
      reset = 1'b1;
      bus.id_rs1 = '0; bus.id_rs2 = '0; bus.ex_rd = '0;
      bus.ex_mem_read = 0; bus.ex_branch_taken = 0; bus.id_halt = 0;
      bus.mem_req = 0; bus.dmem_ready = 0;
      @(posedge clk);
      #1;
      step(1'b1, idle());
      step(1'b1, idle());
      idle_n(2);

      // Load-use on rs2, then the same with x0 as destination (no stall)
      s = idle(); s.mr = 1; s.rd = 5'd5; s.rs2 = 5'd5; step(1'b0, s);
      idle_n(1);
      s = idle(); s.mr = 1; s.rd = 5'd0; s.rs1 = 5'd0; s.rs2 = 5'd0; step(1'b0, s);
      idle_n(1);

      // Taken branch squashes a Halt in ID
      s = idle(); s.br = 1; s.halt = 1; step(1'b0, s);
      idle_n(4);

      // Halt drain, no waits
      s = idle(); s.halt = 1; step(1'b0, s);
      idle_n(6);
      step(1'b1, idle());

      // Halt drain with a memory wait in cycle 2
      s = idle(); s.halt = 1; step(1'b0, s);
      idle_n(1);
      s = idle(); s.mreq = 1; s.dready = 0; step(1'b0, s);
      idle_n(5);
      step(1'b1, idle());

      // Timeout: continuous wait
      s = idle(); s.mreq = 1; s.dready = 0;
      for (int i = 0; i < MEM_TIMEOUT + 3; i++) step(1'b0, s);
      step(1'b1, idle());

      // Wait of MEM_TIMEOUT-1 cycles then ready: no error, counter restarts
      for (int i = 0; i < MEM_TIMEOUT - 1; i++) step(1'b0, s);
      s.dready = 1; step(1'b0, s);
      s.dready = 0;
      for (int i = 0; i < MEM_TIMEOUT - 1; i++) step(1'b0, s);
      idle_n(2);

      // Reset in the middle of a drain
      s = idle(); s.halt = 1; step(1'b0, s);
      idle_n(1);
      step(1'b1, idle());
      idle_n(5);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(99) < 3), rnd());
      end
      idle_n(1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
